// File: rtl/stopwatch_digit_counter_pkg.sv
// Shared types and digit limits for the stopwatch counter; BCD_MODE_EN selects decimal digits.
// Without BCD_MODE_EN each digit counts the full hex range 0-F.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sw_state_e;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

`ifdef BCD_MODE_EN
    localparam digit_t DIGIT_MAX = 4'd9;
`else
    localparam digit_t DIGIT_MAX = 4'd15;
`endif

    function automatic digit_t clamp_digit(input digit_t d);
`ifdef BCD_MODE_EN
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
`else
        return d;
`endif
    endfunction

endpackage

// File: rtl/stopwatch_digit_counter_if.sv
// Command/display bundle between the stopwatch controller (master) and the counter (slave).
interface stopwatch_digit_counter_if
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                          Start;
    logic                          Stop;
    logic                          Clear;
    logic                          Load;
    logic [DIGIT_W*NUM_DIGITS-1:0] LoadValue;
    logic [DIGIT_W*NUM_DIGITS-1:0] Digits;
    logic                          Running;
    logic                          Tick;
    logic                          Overflow;

    modport master (
        output Start, Stop, Clear, Load, LoadValue,
        input  Digits, Running, Tick, Overflow
    );

    modport slave (
        input  Start, Stop, Clear, Load, LoadValue,
        output Digits, Running, Tick, Overflow
    );
endinterface

// File: rtl/stopwatch_digit_counter_rate_divider.sv
// Down-counter issuing TickNow every TICK_DIV enabled cycles.
// Latency: TickNow is combinational from the counter flop; no backpressure.
module rate_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Reload,
    input  logic Enable,
    output logic TickNow
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    assign TickNow = Enable && (div_cnt_q == '0);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (Reload || TickNow) begin
            div_cnt_d = RELOAD_VAL;
        end else if (Enable) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_cnt_q <= RELOAD_VAL;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
endmodule

// File: rtl/stopwatch_digit_counter.sv
// Multi-digit stopwatch up-counter feeding per-digit hex decoders; BCD_MODE_EN selects decimal digits.
// Latency: commands take effect at the sampling edge; Tick/Overflow are registered with the new Digits.
// Backpressure: none; commands are level-sampled every cycle.
module stopwatch_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    stopwatch_digit_counter_if.slave  bus
);
    localparam int BUS_W = DIGIT_W * NUM_DIGITS;

    sw_state_e        state_q;
    logic [BUS_W-1:0] digits_q;
    logic [BUS_W-1:0] digits_d;
    logic [BUS_W-1:0] load_d;
    logic             tick_q;
    logic             ovf_q;
    logic             tick_now;
    logic             all_max;
    logic             carry;
    logic             enter_run;
    logic             reload;
    digit_t           cur;

    assign enter_run = bus.Start && !bus.Stop && (state_q != RUN);
    assign reload    = bus.Clear || bus.Load || enter_run;

    rate_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .Clock   (Clock),
        .Reset   (Reset),
        .Reload  (reload),
        .Enable  (state_q == RUN),
        .TickNow (tick_now)
    );

    // Ripple carry: digit i advances only when every lower digit is at its max.
    always_comb begin
        carry    = 1'b1;
        cur      = '0;
        digits_d = digits_q;
        load_d   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur = digits_q[i*DIGIT_W +: DIGIT_W];
            if (carry) begin
                digits_d[i*DIGIT_W +: DIGIT_W] = (cur == DIGIT_MAX) ? '0 : cur + digit_t'(1);
            end
            carry = carry && (cur == DIGIT_MAX);
            load_d[i*DIGIT_W +: DIGIT_W] = clamp_digit(bus.LoadValue[i*DIGIT_W +: DIGIT_W]);
        end
        all_max = carry;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            digits_q <= '0;
            tick_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (bus.Clear) begin
                state_q  <= IDLE;
                digits_q <= '0;
            end else if (bus.Load) begin
                state_q  <= HOLD;
                digits_q <= load_d;
            end else if (bus.Stop) begin
                // Stop alongside Start still lands in HOLD even from IDLE.
                if (state_q == RUN || bus.Start) begin
                    state_q <= HOLD;
                end
            end else if (enter_run) begin
                state_q <= RUN;
            end else if (tick_now) begin
                digits_q <= digits_d;
                tick_q   <= 1'b1;
                ovf_q    <= all_max;
            end
        end
    end

    assign bus.Digits   = digits_q;
    assign bus.Running  = (state_q == RUN);
    assign bus.Tick     = tick_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_stopwatch_digit_counter.sv
// Directed bench for stopwatch_digit_counter with TICK_DIV=4, two digits.
module tb_stopwatch_digit_counter;
    localparam int TDIV = 4;

`ifdef BCD_MODE_EN
    localparam logic [3:0] DMAX = 4'd9;
`else
    localparam logic [3:0] DMAX = 4'd15;
`endif

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    stopwatch_digit_counter_if #(.NUM_DIGITS(2)) sw_if ();

    stopwatch_digit_counter #(
        .TICK_DIV   (TDIV),
        .NUM_DIGITS (2)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic       load;
        logic [7:0] lv;
        logic [7:0] e_dig;
        logic       e_run;
        logic       e_tick;
        logic       e_ovf;
    } vec_t;

    vec_t tbl [14];

    function automatic logic [7:0] ld(input logic [7:0] x);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = (x[3:0] > DMAX) ? DMAX : x[3:0];
        hi = (x[7:4] > DMAX) ? DMAX : x[7:4];
        return {hi, lo};
    endfunction

    function automatic logic [7:0] incr(input logic [7:0] x);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = x[3:0];
        hi = x[7:4];
        if (lo == DMAX) begin
            lo = 4'd0;
            hi = (hi == DMAX) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic p, input logic c, input logic l, input logic [7:0] v);
        sw_if.Start     = s;
        sw_if.Stop      = p;
        sw_if.Clear     = c;
        sw_if.Load      = l;
        sw_if.LoadValue = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [7:0] d, input logic r, input logic t, input logic o);
        chk({nm, ".digits"}, 32'(sw_if.Digits), 32'(d));
        chk({nm, ".running"}, 32'(sw_if.Running), 32'(r));
        chk({nm, ".tick"}, 32'(sw_if.Tick), 32'(t));
        chk({nm, ".ovf"}, 32'(sw_if.Overflow), 32'(o));
    endtask

    function automatic vec_t mk(input logic s, input logic p, input logic c, input logic l,
                                input logic [7:0] v, input logic [7:0] d,
                                input logic r, input logic t, input logic o);
        vec_t x;
        x.start = s; x.stop = p; x.clear = c; x.load = l; x.lv = v;
        x.e_dig = d; x.e_run = r; x.e_tick = t; x.e_ovf = o;
        return x;
    endfunction

    initial begin
        logic [7:0] exp_d;
        errs   = 0;
        checks = 0;

        tbl[0]  = mk(0, 0, 0, 1, 8'h3C, ld(8'h3C), 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 8'h00, ld(8'h3C), 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 8'h00, ld(8'h3C), 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 8'h55, 8'h00,     0, 0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 8'h00, 8'h00,     0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 8'h00, 8'h00,     1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 8'h00, 8'h00,     1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 8'h00, 8'h00,     1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 8'h00, 8'h00,     1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 8'h00, 8'h01,     1, 1, 0);
        tbl[10] = mk(1, 0, 0, 0, 8'h00, 8'h01,     1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 8'h00, 8'h01,     1, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 8'h00, 8'h01,     1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 8'h00, 8'h02,     1, 1, 0);

        // Reset held with Start asserted.
        rst = 1'b1;
        drive(1, 0, 0, 0, 8'h00);
        repeat (3) step();
        chk_all("reset", 8'h00, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        step();
        chk_all("post_reset", 8'h00, 0, 0, 0);
        drive(1, 0, 0, 0, 8'h00);
        step();
        chk("start_running", 32'(sw_if.Running), 32'd1);
        drive(0, 0, 1, 0, 8'h00);
        step();
        chk_all("clear_idle", 8'h00, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].start, tbl[i].stop, tbl[i].clear, tbl[i].load, tbl[i].lv);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_dig, tbl[i].e_run, tbl[i].e_tick, tbl[i].e_ovf);
        end

        // Wrap from all-max.
        drive(0, 0, 0, 1, 8'hFF);
        step();
        chk_all("ovf_load", ld(8'hFF), 0, 0, 0);
        drive(1, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 0, 8'h00);
        repeat (TDIV - 1) step();
        chk_all("ovf_pre", ld(8'hFF), 1, 0, 0);
        step();
        chk_all("ovf_wrap", 8'h00, 1, 1, 1);
        step();
        chk_all("ovf_after", 8'h00, 1, 0, 0);

        // Load with clamp, then carry into digit 1.
        drive(0, 0, 0, 1, 8'h3C);
        step();
        exp_d = ld(8'h3C);
        chk_all("carry_load", exp_d, 0, 0, 0);
        drive(1, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 0, 8'h00);
        repeat (TDIV) step();
        chk_all("carry_tick", incr(exp_d), 1, 1, 0);

        // Stop exactly when a tick is due suppresses it.
        drive(0, 0, 1, 0, 8'h00);
        step();
        drive(1, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 0, 8'h00);
        repeat (TDIV - 1) step();
        drive(0, 1, 0, 0, 8'h00);
        step();
        chk_all("stop_due", 8'h00, 0, 0, 0);
        drive(0, 0, 0, 0, 8'h00);
        repeat (5) step();
        chk_all("hold_wait", 8'h00, 0, 0, 0);
        drive(1, 0, 0, 0, 8'h00);
        step();
        chk_all("restart", 8'h00, 1, 0, 0);
        drive(0, 0, 0, 0, 8'h00);
        repeat (TDIV - 1) step();
        chk_all("restart_pre", 8'h00, 1, 0, 0);
        step();
        chk_all("restart_tick", 8'h01, 1, 1, 0);

        // Mid-count reset behaves like clear.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("mid_reset", 8'h00, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_digit_counter.md
# stopwatch_digit_counter

- Multi-digit up-counter that produces the 4-bit digit codes driving the seven-segment `hex_decoder` instances, one nibble per display.
- A built-in rate divider advances the count at a fixed tick rate.
- The block has start/stop/clear/load controls and reports wrap-around.
- It sits directly upstream of the per-digit `hex_decoder` instances in the lab top level.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per count increment; legal range ≥1.
- `NUM_DIGITS`, 4: number of 4-bit digits; legal range 1..6.
- `Clock` input 1: single system clock; everything is rising-edge.
- `Reset` input 1: synchronous, active-high reset.
- `Start` input 1: level-sampled; enters RUN.
- `Stop` input 1: level-sampled; enters HOLD.
- `Clear` input 1: zeroes digits; enters IDLE.
- `Load` input 1: loads `LoadValue` into the digits; enters HOLD.
- `LoadValue` input 4*NUM_DIGITS: load data; digit 0 is bits [3:0].
- `Digits` output 4*NUM_DIGITS: current count; digit i is bits [4i+3:4i] and feeds hex_decoder i.
- `Running` output 1: high in RUN.
- `Tick` output 1: one-cycle pulse, coincident with each `Digits` update.
- `Overflow` output 1: one-cycle pulse, coincident with the all-max→all-zero wrap.

## Operation
- **States:**
  - IDLE: stopped, digits zero.
  - RUN: counting.
  - HOLD: stopped, digits retained.
- **Per-cycle command priority:** `Reset` > `Clear` > `Load` > `Stop` > `Start`.
- **Transitions:**
  - `Clear` → IDLE from any state.
  - `Load` → HOLD from any state.
  - `Stop` → HOLD from RUN; ignored in IDLE/HOLD.
  - `Start` → RUN from IDLE/HOLD; ignored in RUN.
  - `Start` and `Stop` together → `Stop` wins.
- **Rate divider:**
  - Down-counter `div_cnt`, width $clog2(TICK_DIV) (min 1).
  - Reloads to TICK_DIV-1 on Reset, Clear, Load, and on any transition into RUN.
  - Decrements only in RUN; frozen in IDLE/HOLD.
  - Internal `tick_now` = RUN && `div_cnt`==0; on that edge `div_cnt` reloads.
  - TICK_DIV=1 gives a tick on every RUN cycle.
- **Digit increment on `tick_now`:**
  - Digit 0 always increments.
  - Digit i increments iff digits 0..i-1 are all at DIGIT_MAX.
  - A digit at DIGIT_MAX that increments becomes 0.
  - All digits at max → all zero, and `Overflow` pulses. Counting continues; no saturation.
- **Load:**
  - Copies `LoadValue` per digit, with an out-of-range clamp to DIGIT_MAX (see Configuration).
  - Divider reloads.
  - No `Tick` is produced.
- Counting in HOLD resumes from the held digits and a fresh divider period.

## Timing
- **Reset values:** state IDLE, `Digits`=0, `Running`=0, `Tick`=0, `Overflow`=0, `div_cnt`=TICK_DIV-1.
- **Command latency:**
  - `Start` sampled at edge N → `Running`=1 from N.
  - First `Tick` at edge N+TICK_DIV.
  - Subsequent ticks every TICK_DIV cycles.
- `Stop`/`Clear`/`Load` at edge N → outputs reflect the new state/digits after edge N.
- A tick due in the same cycle as any of these is suppressed.
- `Tick` and `Overflow` are registered: high for exactly the one cycle following the updating edge, aligned with the new `Digits`.
- `Reset` mid-count behaves like `Clear`; no `Tick`/`Overflow` pulse is produced.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- **`BCD_MODE_EN` defined:**
  - DIGIT_MAX = 9 (decimal display).
  - `LoadValue` digits >9 load as 9.
  - `Digits` never holds A–F.
- **`BCD_MODE_EN` undefined:**
  - DIGIT_MAX = 15 (hex display, 0–F).
  - `LoadValue` is loaded unmodified.

## Structure
- **Package `stopwatch_pkg`:**
  - state enum `sw_state_e` {IDLE, RUN, HOLD}.
  - localparam `DIGIT_W`=4.
  - `DIGIT_MAX`, selected by `BCD_MODE_EN`.
  - typedef `digit_t` = logic [DIGIT_W-1:0].
- **Sub-module `rate_divider`:**
  - Parameter TICK_DIV.
  - Ports `Clock`, `Reset`, `Reload`, `Enable`, `TickNow`.
  - Holds the divider logic; the top holds the FSM and the digit chain.

## Test plan
- Reset held 3 cycles with `Start`=1 → after release, `Digits`=0, `Running`=0; `Start` then gives `Running`=1.
- TICK_DIV=4, NUM_DIGITS=2, `Start` pulse at edge 0 → `Tick` at edges 4, 8, 12; `Digits` 0x01, 0x02, 0x03.
- BCD mode, Load 0x99, Start, TICK_DIV=1 → next cycle `Digits`=0x00, `Overflow`=1 for one cycle, `Tick`=1. Hex mode, Load 0xFF → same result.
- BCD mode, Load 0x3C → `Digits`=0x39. Start → after one period `Digits`=0x40 (carry into digit 1).
- `Start`+`Stop` in the same cycle while IDLE → stays stopped, enters HOLD, `Running`=0. `Clear`+`Load` in the same cycle → `Digits`=0, IDLE.
- Running with a tick due in the same cycle as `Stop` → no `Tick` and `Digits` unchanged. `Start` 5 cycles later → next `Tick` exactly TICK_DIV cycles after it.
